// File: rtl/regfile_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_unit
// Purpose  : Debug snapshot streamer for the MIPS core. On an explicit start
//            pulse or on automatic halt detection (PC unchanged for
//            HALT_CYCLES consecutive cycles) it emits one PC record followed
//            by one record per architectural register over a valid/ready
//            stream, reading the register file via a dedicated read port.
// Ports    : clk, rst_n              - clock, asynchronous active-low reset
//            start                   - single-cycle dump request
//            auto_en                 - enables halt-triggered dumps
//            pc_in                   - current PC from the core
//            rf_raddr / rf_rdata     - register-file read port (combinational)
//            out_valid / out_ready   - record handshake
//            out_is_pc, out_idx,
//            out_data, out_last      - record payload and framing
//            busy                    - dump in progress
//            done                    - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_unit #(
    parameter int DATA_W      = 32,
    parameter int NREG        = 32,
    parameter int ADDR_W      = 5,
    parameter int HALT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              auto_en,
    input  logic [DATA_W-1:0] pc_in,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_pc,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // Halt counter must be able to hold HALT_CYCLES itself (it saturates there).
    localparam int               c_cnt_w    = $clog2(HALT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_halt_max = c_cnt_w'(HALT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_halt_pre = c_cnt_w'(HALT_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  c_last_idx = ADDR_W'(NREG - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND_PC = 3'd1,
        S_FETCH   = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   rf_raddr_q;
    logic                out_valid_q;
    logic                out_is_pc_q;
    logic [ADDR_W-1:0]   out_idx_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;

    // ------------------------------------------------------------------
    // Halt detection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   pc_prev_q;
    logic [c_cnt_w-1:0]  stable_cnt_q;
    logic [c_cnt_w-1:0]  stable_cnt_d;
    logic                w_pc_same;
    logic                w_halt_fire;
    logic                w_trigger;

    always_comb begin
        w_pc_same    = (pc_in == pc_prev_q);
        stable_cnt_d = '0;
        if (w_pc_same) begin
            if (stable_cnt_q == c_halt_max) begin
                stable_cnt_d = stable_cnt_q;
            end else begin
                stable_cnt_d = stable_cnt_q + 1'b1;
            end
        end
    end

    // Fires only on the edge where the counter steps from HALT_CYCLES-1 to
    // HALT_CYCLES. Once saturated it cannot fire again until a PC change
    // clears the counter, which gives the one-shot / re-arm behaviour.
    assign w_halt_fire = auto_en && w_pc_same && (stable_cnt_q == c_halt_pre);
    assign w_trigger   = start || w_halt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_prev_q    <= '0;
            stable_cnt_q <= '0;
        end else begin
            pc_prev_q    <= pc_in;
            stable_cnt_q <= stable_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Dump sequencer with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rf_raddr_q  <= '0;
            out_valid_q <= 1'b0;
            out_is_pc_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Start and halt arriving together collapse into one dump.
                    if (w_trigger) begin
                        out_data_q  <= pc_in;
                        out_is_pc_q <= 1'b1;
                        out_idx_q   <= '0;
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        rf_raddr_q  <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SEND_PC;
                    end
                end
                S_SEND_PC: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        rf_raddr_q  <= '0;
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // rf_raddr_q is held for this whole cycle so the
                    // combinational read data is settled at the edge.
                    out_data_q  <= rf_rdata;
                    out_idx_q   <= rf_raddr_q;
                    out_is_pc_q <= 1'b0;
                    out_last_q  <= (rf_raddr_q == c_last_idx);
                    out_valid_q <= 1'b1;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            out_last_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            rf_raddr_q <= '0;
                            state_q    <= S_DONE;
                        end else begin
                            rf_raddr_q <= rf_raddr_q + 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    // Triggers seen here are dropped, not queued.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rf_raddr  = rf_raddr_q;
    assign out_valid = out_valid_q;
    assign out_is_pc = out_is_pc_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_unit
// Purpose  : Directed self-checking bench for regfile_dump_unit. A scoreboard
//            queue receives the expected records when a dump is provoked and
//            a monitor pops and compares them on every handshake. A second,
//            narrower instance covers the parameterised configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_unit;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int HC  = 4;
    localparam int DWB = 16;
    localparam int NRB = 8;
    localparam int AWB = 3;

    typedef struct packed {
        logic        is_pc;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default configuration
    logic           rst_n, start, auto_en, out_ready;
    logic [DW-1:0]  pc_in, rf_rdata, out_data;
    logic [AW-1:0]  rf_raddr, out_idx;
    logic           out_valid, out_is_pc, out_last, busy, done;
    logic [DW-1:0]  rf [NR];
    assign rf_rdata = rf[rf_raddr];

    // Instance B: NREG=8, ADDR_W=3, DATA_W=16
    logic           start_b, auto_en_b, out_ready_b;
    logic [DWB-1:0] pc_b, rf_rdata_b, out_data_b;
    logic [AWB-1:0] rf_raddr_b, out_idx_b;
    logic           out_valid_b, out_is_pc_b, out_last_b, busy_b, done_b;
    logic [DWB-1:0] rfb [NRB];
    assign rf_rdata_b = rfb[rf_raddr_b];

    regfile_dump_unit #(.DATA_W(DW), .NREG(NR), .ADDR_W(AW), .HALT_CYCLES(HC)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en), .pc_in(pc_in),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_is_pc(out_is_pc), .out_idx(out_idx),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    regfile_dump_unit #(.DATA_W(DWB), .NREG(NRB), .ADDR_W(AWB), .HALT_CYCLES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .auto_en(auto_en_b), .pc_in(pc_b),
        .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_is_pc(out_is_pc_b), .out_idx(out_idx_b),
        .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b), .done(done_b)
    );

    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   hs_cnt    = 0;
    int   stall_cnt = 0;
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    int   t_trig    = 0;
    rec_t sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor for instance A: scoreboard pop, stall stability, done timing.
    rec_t prev_rec   = '0;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        rec_t cur;
        rec_t exp;
        cur = {out_is_pc, out_idx, out_data, out_last};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_stable", 64'({out_valid, cur}), 64'({1'b1, prev_rec}));
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_record", 64'(sb.size()), 64'd1);
                end else begin
                    exp = sb.pop_front();
                    chk("record", 64'(cur), 64'(exp));
                end
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_rec   = cur;
        end
    end

    task automatic push_dump(input logic [31:0] pc);
        sb.push_back({1'b1, 5'd0, pc, 1'b0});
        for (int i = 0; i < NR; i++)
            sb.push_back({1'b0, 5'(i), rf[i], (i == NR - 1)});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t_trig = cyc;
    endtask

    // Wait for done with a cycle bound; optionally randomise out_ready and
    // pulse start mid-dump on iteration start_at.
    task automatic wait_done(input int rand_ready, input int bound, input int start_at);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < bound) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                n++;
                if (rand_ready != 0) out_ready = 1'($urandom_range(0, 1));
                start = (n == start_at);
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int h0, d0, s0, e, vcyc, hb, db, tb_t;
        bit found;
        rec_t qb [$];
        rec_t curb, expb;

        rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; out_ready = 1'b1; pc_in = '0;
        start_b = 1'b0; auto_en_b = 1'b0; out_ready_b = 1'b1; pc_b = 16'h0123;
        for (int i = 0; i < NR; i++)  rf[i]  = 32'h100 + 32'(i);
        for (int i = 0; i < NRB; i++) rfb[i] = 16'hA000 + 16'(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_raddr", 64'(rf_raddr), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Explicit start, out_ready held high
        #1 pc_in = 32'h0000_0040;
        push_dump(32'h40);
        h0 = hs_cnt; d0 = done_cnt;
        pulse_start();
        chk("pc_rec_valid", 64'(out_valid), 64'd1);
        chk("pc_rec_is_pc", 64'(out_is_pc), 64'd1);
        chk("pc_rec_data", 64'(out_data), 64'h40);
        chk("busy_after_trig", 64'(busy), 64'd1);
        wait_done(0, 200, -1);
        chk("t1_done_cycle", 64'(done_cyc), 64'(t_trig + 66));
        chk("t1_handshakes", 64'(hs_cnt - h0), 64'd33);
        chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        chk("t1_done_one_cycle", 64'(done), 64'd0);
        chk("t1_busy_idle", 64'(busy), 64'd0);

        // Back-pressure
        push_dump(32'h40);
        h0 = hs_cnt; s0 = stall_cnt;
        pulse_start();
        wait_done(1, 600, -1);
        chk("t2_done_cycle", 64'(done_cyc), 64'(t_trig + 66 + (stall_cnt - s0)));
        chk("t2_handshakes", 64'(hs_cnt - h0), 64'd33);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Halt detection: PC steps 0,4,8 then holds
        auto_en = 1'b1;
        @(posedge clk); #1 pc_in = 32'h0;
        @(posedge clk); #1 pc_in = 32'h4;
        @(posedge clk); #1 pc_in = 32'h8;
        e = cyc;
        push_dump(32'h8);
        h0 = hs_cnt; d0 = done_cnt;
        vcyc = -1;
        for (int n = 0; n < 20 && vcyc < 0; n++) begin
            @(negedge clk);
            if (out_valid) vcyc = cyc;
        end
        chk("halt_latency", 64'(vcyc), 64'(e + 5));
        wait_done(0, 200, -1);
        chk("t3_handshakes", 64'(hs_cnt - h0), 64'd33);
        repeat (30) @(posedge clk);
        #1;
        chk("t3_no_refire_hs", 64'(hs_cnt - h0), 64'd33);
        chk("t3_no_refire_done", 64'(done_cnt - d0), 64'd1);
        pc_in = 32'hC;
        push_dump(32'hC);
        h0 = hs_cnt;
        wait_done(0, 200, -1);
        chk("t3_second_dump", 64'(hs_cnt - h0), 64'd33);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Simultaneous start + halt, and a start pulse mid-dump
        @(posedge clk); #1 pc_in = 32'h10;
        push_dump(32'h10);
        h0 = hs_cnt; d0 = done_cnt;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(0, 200, 20);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_handshakes", 64'(hs_cnt - h0), 64'd33);
        chk("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);
        auto_en = 1'b0;

        // Reset while record idx 10 is valid
        push_dump(32'h10);
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (out_valid && !out_is_pc && out_idx == 5'd10) found = 1'b1;
        end
        chk("t5_idx10_seen", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_done", 64'(done), 64'd0);
        chk("t5_rst_raddr", 64'(rf_raddr), 64'd0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        h0 = hs_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_resume", 64'(hs_cnt - h0), 64'd0);
        chk("t5_idle_valid", 64'(out_valid), 64'd0);
        push_dump(32'h10);
        pulse_start();
        wait_done(0, 200, -1);
        chk("t5_full_dump", 64'(hs_cnt - h0), 64'd33);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Parameterised instance
        qb.push_back({1'b1, 5'd0, 32'h0000_0123, 1'b0});
        for (int i = 0; i < NRB; i++)
            qb.push_back({1'b0, 5'(i), {16'd0, rfb[i]}, (i == NRB - 1)});
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        tb_t = cyc;
        hb = 0; db = 0;
        for (int n = 0; n < 100 && db == 0; n++) begin
            @(negedge clk);
            if (out_valid_b && out_ready_b) begin
                hb++;
                curb = {out_is_pc_b, {2'b0, out_idx_b}, {16'd0, out_data_b}, out_last_b};
                if (qb.size() == 0) begin
                    chk("b_unexpected_record", 64'(qb.size()), 64'd1);
                end else begin
                    expb = qb.pop_front();
                    chk("b_record", 64'(curb), 64'(expb));
                end
            end
            if (done_b) db = cyc + 1;
        end
        chk("b_handshakes", 64'(hb), 64'd9);
        chk("b_done_cycle", 64'(db), 64'(tb_t + 18));
        chk("b_sb_empty", 64'(qb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
